// File: rtl/pivot_cache_pkg.sv
// Shared types and width helpers for the pivot-layer ROM word cache.
// The client and memory sides of the cache both use the same toggle handshake.
package pivot_cache_pkg;

  localparam int ROM_AW = 27;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    FLUSH,
    IDLE,
    LOOKUP,
    FILL
  } state_t;

  // The tag covers every address bit above the index; bit0 selects a byte and is not stored.
  function automatic int tag_width(input int index_w);
    return ROM_AW - 1 - index_w;
  endfunction

  function automatic int entry_width(input int index_w);
    return DATA_W + tag_width(index_w);
  endfunction

  function automatic logic [15:0] count_inc(input logic [15:0] count, input bit sat);
    if (sat && count == 16'hFFFF) begin
      return count;
    end
    return count + 16'd1;
  endfunction

endpackage

// File: rtl/pivot_rom_cache_if.sv
// Toggle-handshake ROM read bus: the requester flips req, and the responder copies
// req onto ack once data is valid.
interface pivot_rom_cache_if;
  import pivot_cache_pkg::*;

  logic [ROM_AW-1:0] address;
  logic              req;
  logic              ack;
  logic [DATA_W-1:0] data;

  modport master (
    output address,
    output req,
    input  ack,
    input  data
  );

  modport slave (
    input  address,
    input  req,
    output ack,
    output data
  );

endinterface

// File: rtl/dualport_ram_unreg.sv
// Simple dual-port RAM: synchronous write on port A, combinational read on port B.
module dualport_ram_unreg #(
  parameter int WIDTH   = 8,
  parameter int WIDTHAD = 6
) (
  input  logic               clk,
  input  logic [WIDTHAD-1:0] address_a,
  input  logic [WIDTH-1:0]   data_a,
  input  logic               wren_a,
  input  logic [WIDTHAD-1:0] address_b,
  output logic [WIDTH-1:0]   q_b
);

  logic [WIDTH-1:0] mem_array [0:(1<<WIDTHAD)-1];

  always_ff @(posedge clk) begin
    if (wren_a) begin
      mem_array[address_a] <= data_a;
    end
  end

  assign q_b = mem_array[address_b];

endmodule

// File: rtl/pivot_rom_cache.sv
// Direct-mapped word cache between the pivot-layer pixel FIFO and the SDRAM ROM channel.
// Repeated reads of the same 16-bit word are answered locally.
module pivot_rom_cache
  import pivot_cache_pkg::*;
#(
  parameter int INDEX_W   = 6,
  parameter bit SAT_COUNT = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  pivot_rom_cache_if.slave  cli,
  pivot_rom_cache_if.master mem,
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count
);

  localparam int TAG_W   = tag_width(INDEX_W);
  localparam int ENTRY_W = entry_width(INDEX_W);
  localparam int DEPTH   = 1 << INDEX_W;
  localparam logic [INDEX_W-1:0] LAST_IDX = INDEX_W'(DEPTH - 1);

  state_t state_reg, state_next;

  logic [ROM_AW-1:1]  addr_reg;
  logic [INDEX_W-1:0] flush_idx_reg;
  logic               flush_pending_reg;
  logic               valid_reg [DEPTH];
  logic               cli_ack_reg;
  logic [15:0]        cli_data_reg;
  logic [ROM_AW-1:0]  mem_addr_reg;
  logic               mem_req_reg;
  logic [15:0]        hit_count_reg;
  logic [15:0]        miss_count_reg;

  logic [INDEX_W-1:0] index;
  logic [TAG_W-1:0]   tag;
  logic [ENTRY_W-1:0] rd_entry;
  logic [TAG_W-1:0]   rd_tag;
  logic [15:0]        rd_data;
  logic               lookup_hit;
  logic               mem_idle;
  logic               cli_pending;
  logic               unused_addr_bit0;

  // Strobes from the output decoder.
  logic clear_valid;
  logic latch_addr;
  logic hit_done;
  logic count_miss;
  logic issue_fill;
  logic fill_done;

  assign index       = addr_reg[INDEX_W:1];
  assign tag         = addr_reg[ROM_AW-1:INDEX_W+1];
  assign rd_tag      = rd_entry[ENTRY_W-1:16];
  assign rd_data     = rd_entry[15:0];
  assign lookup_hit  = valid_reg[index] && (rd_tag == tag);
  assign mem_idle    = (mem.ack == mem_req_reg);
  assign cli_pending = (cli.req != cli_ack_reg);
  assign unused_addr_bit0 = cli.address[0];

  dualport_ram_unreg #(
    .WIDTH   (ENTRY_W),
    .WIDTHAD (INDEX_W)
  ) u_store (
    .clk       (clk),
    .address_a (index),
    .data_a    ({tag, mem.data}),
    .wren_a    (fill_done),
    .address_b (index),
    .q_b       (rd_entry)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= FLUSH;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      FLUSH: begin
        // Only leave once a fill orphaned by reset has been returned.
        if (!flush && flush_idx_reg == LAST_IDX && mem_idle) begin
          state_next = IDLE;
        end
      end
      IDLE: begin
        if (flush) begin
          state_next = FLUSH;
        end else if (cli_pending) begin
          state_next = LOOKUP;
        end
      end
      LOOKUP: begin
        if (flush) begin
          state_next = FLUSH;
        end else if (lookup_hit) begin
          state_next = IDLE;
        end else begin
          state_next = FILL;
        end
      end
      FILL: begin
        if (mem_idle) begin
          state_next = (flush_pending_reg || flush) ? FLUSH : IDLE;
        end
      end
      default: state_next = FLUSH;
    endcase
  end

  always_comb begin
    clear_valid = 1'b0;
    latch_addr  = 1'b0;
    hit_done    = 1'b0;
    count_miss  = 1'b0;
    issue_fill  = 1'b0;
    fill_done   = 1'b0;
    case (state_reg)
      FLUSH:  clear_valid = 1'b1;
      IDLE:   latch_addr  = cli_pending;
      LOOKUP: begin
        if (lookup_hit) begin
          hit_done = 1'b1;
        end else begin
          count_miss = 1'b1;
          // A flush in this cycle defers the request until the flush is over.
          issue_fill = !flush;
        end
      end
      FILL:    fill_done = mem_idle;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_reg          <= '0;
      cli_ack_reg       <= cli.req;
      cli_data_reg      <= 16'h0000;
      mem_addr_reg      <= '0;
      hit_count_reg     <= 16'h0000;
      miss_count_reg    <= 16'h0000;
      flush_idx_reg     <= '0;
      flush_pending_reg <= 1'b0;
    end else begin
      if (latch_addr) begin
        addr_reg <= cli.address[ROM_AW-1:1];
      end
      if (hit_done) begin
        cli_data_reg  <= rd_data;
        cli_ack_reg   <= ~cli_ack_reg;
        hit_count_reg <= count_inc(hit_count_reg, SAT_COUNT);
      end
      if (fill_done) begin
        cli_data_reg <= mem.data;
        cli_ack_reg  <= ~cli_ack_reg;
      end
      if (count_miss) begin
        miss_count_reg <= count_inc(miss_count_reg, SAT_COUNT);
      end
      if (issue_fill) begin
        mem_addr_reg <= {addr_reg, 1'b0};
      end
      if (state_reg != FLUSH || flush) begin
        flush_idx_reg <= '0;
      end else begin
        flush_idx_reg <= flush_idx_reg + 1'b1;
      end
      if (state_reg == FLUSH) begin
        flush_pending_reg <= 1'b0;
      end else if (flush) begin
        flush_pending_reg <= 1'b1;
      end
    end
  end

  // The memory toggle survives reset so an in-flight SDRAM read stays matched.
  always_ff @(posedge clk) begin
    if (!reset && issue_fill) begin
      mem_req_reg <= ~mem_req_reg;
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
    always_ff @(posedge clk) begin
      if (reset) begin
        valid_reg[gi] <= 1'b0;
      end else if (clear_valid && flush_idx_reg == INDEX_W'(gi)) begin
        valid_reg[gi] <= 1'b0;
      end else if (fill_done && index == INDEX_W'(gi)) begin
        valid_reg[gi] <= 1'b1;
      end
    end
  end

  assign cli.ack     = cli_ack_reg;
  assign cli.data    = cli_data_reg;
  assign mem.address = mem_addr_reg;
  assign mem.req     = mem_req_reg;
  assign hit_count   = hit_count_reg;
  assign miss_count  = miss_count_reg;

endmodule

// File: tb/tb_pivot_rom_cache.sv
// Directed bench for pivot_rom_cache: misses, hits, conflicts, flush during fill,
// reset with a fill in flight, and hit counter saturation.
module tb_pivot_rom_cache;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  int vectors     = 0;
  int miscompares = 0;
  int toggles     = 0;
  bit resp_en     = 1'b1;

  pivot_rom_cache_if cli_bus ();
  pivot_rom_cache_if mem_bus ();

  pivot_rom_cache #(
    .INDEX_W   (6),
    .SAT_COUNT (1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .cli        (cli_bus),
    .mem        (mem_bus),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 clk = ~clk;

  // Memory image: one distinctive word, everything else derived from the address.
  function automatic logic [15:0] rom_word(input logic [26:0] a);
    if (a == 27'h000100) begin
      return 16'hBEEF;
    end
    return a[16:1] ^ 16'hA5A5;
  endfunction

  // SDRAM responder: answers an outstanding toggle three cycles after seeing it.
  initial begin
    mem_bus.ack  = 1'b0;
    mem_bus.data = 16'h0000;
    forever begin
      @(posedge clk); #1;
      if (resp_en && mem_bus.req !== mem_bus.ack) begin
        repeat (3) begin
          @(posedge clk); #1;
        end
        mem_bus.data = rom_word(mem_bus.address);
        mem_bus.ack  = mem_bus.req;
      end
    end
  end

  initial begin
    logic prev_req;
    @(negedge reset);
    prev_req = mem_bus.req;
    forever begin
      @(posedge clk); #2;
      if (mem_bus.req !== prev_req) begin
        toggles++;
        prev_req = mem_bus.req;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_ack(output int lat);
    lat = 0;
    while (cli_bus.ack !== cli_bus.req && lat < 400) begin
      @(posedge clk); #1;
      lat++;
    end
    check_vec("ack_timeout", 32'(cli_bus.ack), 32'(cli_bus.req));
  endtask

  task automatic cli_read(input logic [26:0] a, output int lat);
    cli_bus.address = a;
    cli_bus.req     = ~cli_bus.req;
    wait_ack(lat);
    $display("read addr=%h lat=%0d data=%h hits=%0d misses=%0d",
             a, lat, cli_bus.data, hit_count, miss_count);
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int lat;
    int t0;
    logic saved_req;

    // Reset with the client toggle high: ack must follow it.
    reset           = 1'b1;
    flush           = 1'b0;
    cli_bus.req     = 1'b1;
    cli_bus.address = 27'h0;
    cycles(3);
    check_vec("rst_cli_ack", 32'(cli_bus.ack), 32'd1);
    check_vec("rst_cli_data", 32'(cli_bus.data), 32'h0);
    check_vec("rst_hit", 32'(hit_count), 32'h0);
    check_vec("rst_miss", 32'(miss_count), 32'h0);
    check_vec("rst_mem_addr", 32'(mem_bus.address), 32'h0);
    reset = 1'b0;
    cycles(70);

    // Cold miss.
    t0 = toggles;
    cli_read(27'h000100, lat);
    check_vec("miss1_data", 32'(cli_bus.data), 32'hBEEF);
    check_vec("miss1_count", 32'(miss_count), 32'd1);
    check_vec("miss1_toggles", 32'(toggles - t0), 32'd1);
    check_vec("miss1_mem_addr", 32'(mem_bus.address), 32'h000100);

    // Same word through the odd byte address: hit with two-cycle latency.
    t0 = toggles;
    cli_read(27'h000101, lat);
    check_vec("hit1_lat", 32'(lat), 32'd2);
    check_vec("hit1_data", 32'(cli_bus.data), 32'hBEEF);
    check_vec("hit1_count", 32'(hit_count), 32'd1);
    check_vec("hit1_toggles", 32'(toggles - t0), 32'd0);

    // Conflict on index 0: both reads miss.
    t0 = toggles;
    cli_read(27'h000080, lat);
    check_vec("conf_a_data", 32'(cli_bus.data), 32'hA5E5);
    cli_read(27'h000100, lat);
    check_vec("conf_b_data", 32'(cli_bus.data), 32'hBEEF);
    check_vec("conf_miss", 32'(miss_count), 32'd3);
    check_vec("conf_toggles", 32'(toggles - t0), 32'd2);
    check_vec("conf_mem_addr", 32'(mem_bus.address), 32'h000100);

    // Flush pulse while the fill for 0x200 is outstanding.
    cli_bus.address = 27'h000200;
    cli_bus.req     = ~cli_bus.req;
    cycles(3);
    flush = 1'b1;
    cycles(1);
    flush = 1'b0;
    wait_ack(lat);
    $display("read addr=%h lat=%0d data=%h (flushed fill)", cli_bus.address, lat, cli_bus.data);
    check_vec("flfill_data", 32'(cli_bus.data), 32'hA4A5);
    check_vec("flfill_miss", 32'(miss_count), 32'd4);
    cycles(70);
    t0 = toggles;
    cli_read(27'h000200, lat);
    check_vec("flre_data", 32'(cli_bus.data), 32'hA4A5);
    check_vec("flre_miss", 32'(miss_count), 32'd5);
    check_vec("flre_toggles", 32'(toggles - t0), 32'd1);

    // Hit counter saturation.
    cli_read(27'h000201, lat);
    check_vec("sat_pre_hit", 32'(hit_count), 32'd2);
    force dut.hit_count_reg = 16'hFFFE;
    #0;
    release dut.hit_count_reg;
    cli_read(27'h000201, lat);
    check_vec("sat_hit1", 32'(hit_count), 32'hFFFF);
    cli_read(27'h000201, lat);
    check_vec("sat_hit2", 32'(hit_count), 32'hFFFF);
    cli_read(27'h000200, lat);
    check_vec("sat_hit3", 32'(hit_count), 32'hFFFF);
    check_vec("sat_data", 32'(cli_bus.data), 32'hA4A5);

    // Reset while a fill is in flight.
    resp_en         = 1'b0;
    cli_bus.address = 27'h000300;
    cli_bus.req     = ~cli_bus.req;
    cycles(4);
    check_vec("inflight_req", 32'(mem_bus.req != mem_bus.ack), 32'd1);
    saved_req = mem_bus.req;
    reset     = 1'b1;
    cycles(1);
    check_vec("rst2_cli_ack", 32'(cli_bus.ack), 32'(cli_bus.req));
    check_vec("rst2_mem_req", 32'(mem_bus.req), 32'(saved_req));
    check_vec("rst2_miss", 32'(miss_count), 32'h0);
    reset = 1'b0;
    t0    = toggles;
    cli_bus.req = ~cli_bus.req;
    cycles(100);
    check_vec("stall_mem_req", 32'(mem_bus.req), 32'(saved_req));
    check_vec("stall_pending", 32'(cli_bus.ack != cli_bus.req), 32'd1);
    resp_en = 1'b1;
    wait_ack(lat);
    $display("read addr=%h lat=%0d data=%h (after reset drain)", cli_bus.address, lat, cli_bus.data);
    check_vec("drain_data", 32'(cli_bus.data), 32'hA425);
    check_vec("drain_miss", 32'(miss_count), 32'd1);
    check_vec("drain_toggles", 32'(toggles - t0), 32'd1);
    check_vec("drain_mem_addr", 32'(mem_bus.address), 32'h000300);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
